banked_mem_decoder: RTL and testbench

Parametrised, registered memory decoder fronting NUM_BANKS ROM banks and NUM_BANKS SRAM banks behind a single valid/ready request/response interface. It succeeds the fixed 8x8 ROM/SRAM decoder and adds:
- generalised width, depth and bank count
- one-cycle registered read latency with response backpressure
- automatic SRAM clear after reset
- error reporting on writes to ROM space
It sits between a simple master (testbench or CPU stub) and on-chip storage.

---
 rtl/banked_mem_decoder_pkg.sv | 26 ++
 rtl/banked_mem_sram_bank.sv | 23 ++
 rtl/banked_mem_decoder.sv | 151 +++++++++++++++
 tb/tb_banked_mem_decoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_decoder_pkg.sv
// Shared state encodings, region codes and ROM content generator for banked_mem_decoder.
package banked_mem_decoder_pkg;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic REGION_ROM  = 1'b0;
    localparam logic REGION_SRAM = 1'b1;

    // fib(0) = fib(1) = 1; wraps silently for large n, callers truncate anyway.
    function automatic int unsigned fib(input int unsigned n);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 1;
        b = 1;
        for (int unsigned i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

endpackage

// File: rtl/banked_mem_sram_bank.sv
// One SRAM bank: synchronous write, combinational read on the same address.
module banked_mem_sram_bank #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BANK_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [$clog2(BANK_DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]             i_wdata,
    output logic [DATA_W-1:0]             o_rdata
);

    logic [DATA_W-1:0] r_mem [BANK_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/banked_mem_decoder.sv
// Registered ROM/SRAM bank decoder with valid/ready handshake and post-reset SRAM clear.
// Optional BANKED_MEM_DECODER_ERR_CNT_EN adds a saturating count of illegal ROM writes.
module banked_mem_decoder
    import banked_mem_decoder_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_BANKS  = 8,
    parameter int unsigned BANK_DEPTH = 8,
    parameter int unsigned ADDR_W     = 1 + $clog2(NUM_BANKS) + $clog2(BANK_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
`ifdef BANKED_MEM_DECODER_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned WORD_W = $clog2(BANK_DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WORD_W-1:0] r_cnt;
    logic              r_init_done;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_region;
    logic [BANK_W-1:0] w_bank;
    logic [WORD_W-1:0] w_word;
    logic              w_init;
    logic              w_cnt_last;
    logic              w_accept;
    logic              w_rom_wr;
    logic [DATA_W-1:0] w_rom_word;
    logic [WORD_W-1:0] w_bank_addr;
    logic [DATA_W-1:0] w_bank_wdata;
    logic [DATA_W-1:0] w_bank_rdata [NUM_BANKS];

    assign w_region   = req_addr[ADDR_W-1];
    assign w_bank     = req_addr[WORD_W +: BANK_W];
    assign w_word     = req_addr[WORD_W-1:0];
    assign w_init     = (r_state == ST_INIT);
    assign w_cnt_last = (r_cnt == WORD_W'(BANK_DEPTH - 1));

    // In RESP a new request can only be taken when the current response drains.
    assign req_ready = (r_state == ST_IDLE) | ((r_state == ST_RESP) & rsp_ready);
    assign w_accept  = req_valid & req_ready;
    assign w_rom_wr  = req_we & (w_region == REGION_ROM);

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign init_done = r_init_done;

    always_comb begin
        w_rom_word = DATA_W'(fib(32'(w_word)) + 32'(w_bank));
    end

    // During INIT every bank is cleared in lockstep at the counter address.
    assign w_bank_addr  = w_init ? r_cnt : w_word;
    assign w_bank_wdata = w_init ? '0 : req_wdata;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_we;
        assign w_we = w_init |
                      (w_accept & req_we & (w_region == REGION_SRAM) & (w_bank == BANK_W'(b)));

        banked_mem_sram_bank #(
            .DATA_W    (DATA_W),
            .BANK_DEPTH(BANK_DEPTH)
        ) u_bank (
            .clk    (clk),
            .i_we   (w_we),
            .i_addr (w_bank_addr),
            .i_wdata(w_bank_wdata),
            .o_rdata(w_bank_rdata[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_cnt_last) w_state_nxt = ST_IDLE;
            ST_IDLE: if (req_valid) w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready && !req_valid) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Clear counter, sticky init flag and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_init) begin
                r_cnt <= r_cnt + WORD_W'(1);
                if (w_cnt_last) begin
                    r_init_done <= 1'b1;
                end
            end
            if (w_accept) begin
                r_rsp_err <= w_rom_wr;
                if (w_region == REGION_ROM) begin
                    r_rsp_rdata <= w_rom_word;
                end else if (req_we) begin
                    r_rsp_rdata <= req_wdata;
                end else begin
                    r_rsp_rdata <= w_bank_rdata[w_bank];
                end
            end
        end
    end

`ifdef BANKED_MEM_DECODER_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_accept && w_rom_wr && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_banked_mem_decoder.sv
// Scoreboard bench for banked_mem_decoder at default parameters.
module tb_banked_mem_decoder;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       init_done;
`ifdef BANKED_MEM_DECODER_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int   n_cmp;
    int   n_bad;
    exp_t sb[$];
    logic [7:0] sram_model [64];

    banked_mem_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .init_done(init_done)
`ifdef BANKED_MEM_DECODER_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rom_ref(input int b, input int w);
        int fibt[8];
        fibt = '{1, 1, 2, 3, 5, 8, 13, 21};
        return 8'(fibt[w] + b);
    endfunction

    // Samples one cycle at negedge+1, records accepted requests into the scoreboard.
    task automatic step(output logic acc, output logic hs, output logic [7:0] rd, output logic er);
        exp_t e;
        #1;
        acc = req_valid & req_ready;
        hs  = rsp_valid & rsp_ready;
        rd  = rsp_rdata;
        er  = rsp_err;
        if (acc) begin
            if (req_addr[6]) begin
                if (req_we) begin
                    sram_model[req_addr[5:0]] = req_wdata;
                    e.rdata = req_wdata;
                end else begin
                    e.rdata = sram_model[req_addr[5:0]];
                end
                e.err = 1'b0;
            end else begin
                e.rdata = rom_ref(int'(req_addr[5:3]), int'(req_addr[2:0]));
                e.err   = req_we;
            end
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [6:0] a, input logic [7:0] d,
                         output logic ok, output int waited);
        logic acc, hs, er;
        logic [7:0] rd;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        ok        = 1'b0;
        waited    = 0;
        for (int i = 0; i < 40; i++) begin
            step(acc, hs, rd, er);
            if (acc) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, init_done} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%0d err=%b done=%b expected all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, init_done);
        end
`ifdef BANKED_MEM_DECODER_ERR_CNT_EN
        n_cmp++;
        if (err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_init();
        logic ok, acc, hs, er;
        logic [7:0] rd;
        int waited;
        exp_t e;
        rst_n = 1'b1;
        issue(1'b0, 7'b1010011, 8'd0, ok, waited);
        n_cmp++;
        if (!ok || waited != 8) begin
            n_bad++;
            $display("FAIL init_ready_low: got ok=%b low_cycles=%0d expected ok=1 low_cycles=8", ok, waited);
        end
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_bad++;
            $display("FAIL init_done: got %b expected 1", init_done);
        end
        step(acc, hs, rd, er);
        n_cmp++;
        if (!hs || sb.size() == 0) begin
            n_bad++;
            $display("FAIL init_rsp_latency: got hs=%b queued=%0d expected hs=1", hs, sb.size());
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (rd !== e.rdata || er !== e.err || rd !== 8'd0) begin
                n_bad++;
                $display("FAIL init_first_rsp: got rdata=%0d err=%b expected rdata=%0d err=%b",
                         rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_rom_read();
        logic [6:0] addrs[2];
        logic [7:0] want[2];
        logic ok, acc, hs, er;
        logic [7:0] rd;
        int waited;
        exp_t e;
        addrs = '{7'b0000101, 7'b0011111};
        want  = '{8'd8, 8'd24};
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, addrs[i], 8'd0, ok, waited);
            step(acc, hs, rd, er);
            n_cmp++;
            if (!ok || !hs || sb.size() == 0) begin
                n_bad++;
                $display("FAIL rom_read_latency[%0d]: got ok=%b hs=%b expected 1/1", i, ok, hs);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (rd !== e.rdata || er !== 1'b0 || rd !== want[i]) begin
                    n_bad++;
                    $display("FAIL rom_read[%0d]: got rdata=%0d err=%b expected rdata=%0d err=0",
                             i, rd, er, want[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc1, acc2, acc, hs, er;
        logic [7:0] rd;
        exp_t e;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 7'b1001001;
        req_wdata = 8'd15;
        step(acc1, hs, rd, er);
        req_we = 1'b0;
        step(acc2, hs, rd, er);
        n_cmp++;
        if (!acc1 || !acc2 || !hs || sb.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_accept: got acc1=%b acc2=%b hs=%b expected 1/1/1", acc1, acc2, hs);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (rd !== e.rdata || er !== e.err || rd !== 8'd15) begin
                n_bad++;
                $display("FAIL b2b_write_echo: got rdata=%0d err=%b expected rdata=15 err=0", rd, er);
            end
        end
        req_valid = 1'b0;
        step(acc, hs, rd, er);
        n_cmp++;
        if (!hs || sb.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_second_rsp: got hs=%b expected 1", hs);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (rd !== e.rdata || er !== e.err || rd !== 8'd15) begin
                n_bad++;
                $display("FAIL b2b_readback: got rdata=%0d err=%b expected rdata=15 err=0", rd, er);
            end
        end
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got rsp_valid=%b expected 0", rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_rom_write();
        logic ok, acc, hs, er;
        logic [7:0] rd;
        int waited;
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            issue(pass == 0, 7'b0000000, 8'd5, ok, waited);
            step(acc, hs, rd, er);
            n_cmp++;
            if (!ok || !hs || sb.size() == 0) begin
                n_bad++;
                $display("FAIL rom_wr_handshake[%0d]: got ok=%b hs=%b expected 1/1", pass, ok, hs);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (rd !== e.rdata || er !== e.err || rd !== 8'd1) begin
                    n_bad++;
                    $display("FAIL rom_wr[%0d]: got rdata=%0d err=%b expected rdata=%0d err=%b",
                             pass, rd, er, e.rdata, e.err);
                end
            end
`ifdef BANKED_MEM_DECODER_ERR_CNT_EN
            n_cmp++;
            if (err_cnt !== 8'd1) begin
                n_bad++;
                $display("FAIL err_cnt[%0d]: got %0d expected 1", pass, err_cnt);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic ok, acc, hs, er;
        logic [7:0] rd;
        int waited;
        exp_t e;
        rsp_ready = 1'b0;
        issue(1'b0, 7'b0111010, 8'd0, ok, waited);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'd9 || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdata=%0d rdy=%b expected vld=1 rdata=9 rdy=0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            step(acc, hs, rd, er);
        end
        rsp_ready = 1'b1;
        step(acc, hs, rd, er);
        n_cmp++;
        if (!ok || !hs || sb.size() == 0) begin
            n_bad++;
            $display("FAIL bp_release: got ok=%b hs=%b expected 1/1", ok, hs);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (rd !== e.rdata || er !== e.err) begin
                n_bad++;
                $display("FAIL bp_data: got rdata=%0d err=%b expected rdata=%0d err=%b",
                         rd, er, e.rdata, e.err);
            end
        end
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_idle: got vld=%b rdy=%b expected vld=0 rdy=1", rsp_valid, req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic ok, acc, hs, er;
        logic [7:0] rd;
        int waited;
        exp_t e;
        issue(1'b1, 7'b1010011, 8'hA5, ok, waited);
        step(acc, hs, rd, er);
        if (sb.size() != 0) e = sb.pop_front();
        n_cmp++;
        if (!hs || rd !== 8'hA5) begin
            n_bad++;
            $display("FAIL rm_setup_write: got hs=%b rdata=%0d expected hs=1 rdata=165", hs, rd);
        end
        rsp_ready = 1'b0;
        issue(1'b0, 7'b1010011, 8'd0, ok, waited);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0 || rsp_rdata !== 8'd0) begin
            n_bad++;
            $display("FAIL rm_async_reset: got vld=%b rdy=%b done=%b rdata=%0d expected 0/0/0/0",
                     rsp_valid, req_ready, init_done, rsp_rdata);
        end
        sb.delete();
        for (int i = 0; i < 64; i++) sram_model[i] = 8'd0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        issue(1'b0, 7'b1010011, 8'd0, ok, waited);
        n_cmp++;
        if (!ok || waited != 8) begin
            n_bad++;
            $display("FAIL rm_reinit: got ok=%b low_cycles=%0d expected ok=1 low_cycles=8", ok, waited);
        end
        step(acc, hs, rd, er);
        n_cmp++;
        if (!hs || sb.size() == 0) begin
            n_bad++;
            $display("FAIL rm_rsp: got hs=%b expected 1", hs);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (rd !== e.rdata || er !== e.err || rd !== 8'd0) begin
                n_bad++;
                $display("FAIL rm_cleared: got rdata=%0d err=%b expected rdata=0 err=0", rd, er);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) sram_model[i] = 8'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_init();
        test_rom_read();
        test_back_to_back();
        test_rom_write();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
